// File: rtl/plic_controller.sv
// plic_controller: latches peripheral interrupt requests, arbitrates by programmable priority and
// exposes xv6-style priority/pending/enable/threshold/claim registers. Define PLIC_EDGE_TRIGGER_EN for edge-triggered sources.
module plic_controller #(
    parameter int unsigned NUM_SRC   = 8,
    parameter int unsigned PRIO_W    = 3,
    parameter logic [31:0] BASE_ADDR = 32'h0C00_0000
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NUM_SRC-1:0] i_irq,
    input  logic [31:0]        i_bus_data,
    input  logic [31:0]        i_bus_address,
    input  logic               i_bus_DV,
    input  logic [2:0]         i_bhw,
    input  logic               i_write_notread,
    output logic [31:0]        o_bus_data,
    output logic               o_bus_DV,
    output logic               o_interrupt,
    input  logic               i_ack,
    output logic [4:0]         o_claim_id
);
    localparam int unsigned ID_W  = 5;
    localparam int unsigned OFF_W = 22;
    localparam int unsigned IDX_W = 10;
    localparam logic [31:0]        SPAN      = 32'h003F_FFFF;
    localparam logic [OFF_W-1:0]   OFF_PEND  = 22'h00_1000;
    localparam logic [OFF_W-1:0]   OFF_EN    = 22'h00_2000;
    localparam logic [OFF_W-1:0]   OFF_THR   = 22'h20_0000;
    localparam logic [OFF_W-1:0]   OFF_CLAIM = 22'h20_0004;
    localparam logic [NUM_SRC-1:0] SRC_MASK  = {{(NUM_SRC-1){1'b1}}, 1'b0};

    logic [PRIO_W-1:0]  prio     [NUM_SRC];
    logic [PRIO_W-1:0]  prio_n   [NUM_SRC];
    logic [NUM_SRC-1:0] enable, enable_n;
    logic [NUM_SRC-1:0] pending, pending_n;
    logic [NUM_SRC-1:0] inflight, inflight_n;
    logic [NUM_SRC-1:0] req;
    logic [PRIO_W-1:0]  threshold, threshold_n;
    logic               hold, hold_n;

    logic [ID_W-1:0]    win_id;
    logic [PRIO_W-1:0]  win_prio;

    logic [31:0]        offset;
    logic [OFF_W-1:0]   off;
    logic [IDX_W-1:0]   prio_idx;
    logic               in_range, acc, wr, rd, is_prio, is_claim;
    logic [31:0]        rdata;

    logic               unused_bhw;
    assign unused_bhw = ^i_bhw;

    // Request condition: level of i_irq, or its rising edge against a registered copy.
`ifdef PLIC_EDGE_TRIGGER_EN
    logic [NUM_SRC-1:0] irq_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            irq_q <= '0;
        end else begin
            irq_q <= i_irq;
        end
    end

    assign req = i_irq & ~irq_q & SRC_MASK;
`else
    assign req = i_irq & SRC_MASK;
`endif

    // Address decode: only the 4 MiB window at BASE_ADDR is accepted.
    always_comb begin
        offset   = i_bus_address - BASE_ADDR;
        in_range = (i_bus_address >= BASE_ADDR) && (offset <= SPAN);
        off      = offset[OFF_W-1:0];
        prio_idx = off[11:2];
        is_prio  = (off[21:12] == '0) && (off[1:0] == 2'b00);
        is_claim = (off == OFF_CLAIM);
        acc      = i_bus_DV && in_range;
        wr       = acc && i_write_notread;
        rd       = acc && !i_write_notread;
    end

    // Arbitration: highest priority above threshold wins; strict compare keeps the lowest id on ties.
    always_comb begin
        win_id   = '0;
        win_prio = '0;
        for (int i = 1; i < int'(NUM_SRC); i++) begin
            if (pending[i] && enable[i] && (prio[i] != '0) && (prio[i] > threshold) &&
                ((win_id == '0) || (prio[i] > win_prio))) begin
                win_id   = ID_W'(i);
                win_prio = prio[i];
            end
        end
    end

    // Read mux over pre-edge state; unmapped offsets and reserved priority slots read 0.
    always_comb begin
        rdata = '0;
        if (is_prio) begin
            for (int i = 1; i < int'(NUM_SRC); i++) begin
                if (prio_idx == IDX_W'(i)) begin
                    rdata = 32'(prio[i]);
                end
            end
        end else if (off == OFF_PEND) begin
            rdata = 32'(pending);
        end else if (off == OFF_EN) begin
            rdata = 32'(enable);
        end else if (off == OFF_THR) begin
            rdata = 32'(threshold);
        end else if (is_claim) begin
            rdata = 32'(win_id);
        end
    end

    // Next state: gateway set first, then register writes, then claim (claim clear beats a same-cycle set).
    always_comb begin
        prio_n      = prio;
        enable_n    = enable;
        threshold_n = threshold;
        pending_n   = pending | (req & ~inflight);
        inflight_n  = inflight;
        hold_n      = hold | i_ack;

        if (wr) begin
            if (is_prio) begin
                for (int i = 1; i < int'(NUM_SRC); i++) begin
                    if (prio_idx == IDX_W'(i)) begin
                        prio_n[i] = i_bus_data[PRIO_W-1:0];
                    end
                end
            end
            if (off == OFF_EN) begin
                enable_n = i_bus_data[NUM_SRC-1:0] & SRC_MASK;
            end
            if (off == OFF_THR) begin
                threshold_n = i_bus_data[PRIO_W-1:0];
            end
            if (is_claim) begin
                for (int i = 1; i < int'(NUM_SRC); i++) begin
                    if ((i_bus_data == 32'(i)) && inflight[i]) begin
                        inflight_n[i] = 1'b0;
                    end
                end
            end
        end

        if (rd && is_claim && (win_id != '0)) begin
            for (int i = 1; i < int'(NUM_SRC); i++) begin
                if (win_id == ID_W'(i)) begin
                    pending_n[i]  = 1'b0;
                    inflight_n[i] = 1'b1;
                end
            end
            hold_n = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(NUM_SRC); i++) begin
                prio[i] <= '0;
            end
            enable      <= '0;
            threshold   <= '0;
            pending     <= '0;
            inflight    <= '0;
            hold        <= 1'b0;
            o_bus_DV    <= 1'b0;
            o_bus_data  <= '0;
            o_interrupt <= 1'b0;
            o_claim_id  <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_SRC); i++) begin
                prio[i] <= prio_n[i];
            end
            enable      <= enable_n;
            threshold   <= threshold_n;
            pending     <= pending_n;
            inflight    <= inflight_n;
            hold        <= hold_n;
            o_bus_DV    <= acc;
            o_bus_data  <= rd ? rdata : '0;
            o_interrupt <= (win_id != '0) && !hold;
            o_claim_id  <= win_id;
        end
    end

endmodule

// File: tb/tb_plic_controller.sv
// Testbench for plic_controller: register table, directed interrupt sequences and a random run
// checked every cycle against a behavioural model of the controller.
module tb_plic_controller;
    localparam int unsigned NUM_SRC = 8;
    localparam int unsigned PRIO_W  = 3;
    localparam logic [31:0] BASE   = 32'h0C00_0000;
    localparam logic [31:0] A_PEND = BASE + 32'h0000_1000;
    localparam logic [31:0] A_EN   = BASE + 32'h0000_2000;
    localparam logic [31:0] A_THR  = BASE + 32'h0020_0000;
    localparam logic [31:0] A_CLM  = BASE + 32'h0020_0004;

    logic               i_clk = 1'b0;
    logic               i_rst_n;
    logic [NUM_SRC-1:0] i_irq;
    logic [31:0]        i_bus_data;
    logic [31:0]        i_bus_address;
    logic               i_bus_DV;
    logic [2:0]         i_bhw;
    logic               i_write_notread;
    logic [31:0]        o_bus_data;
    logic               o_bus_DV;
    logic               o_interrupt;
    logic               i_ack;
    logic [4:0]         o_claim_id;

    plic_controller #(.NUM_SRC(NUM_SRC), .PRIO_W(PRIO_W), .BASE_ADDR(BASE)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_irq(i_irq), .i_bus_data(i_bus_data),
        .i_bus_address(i_bus_address), .i_bus_DV(i_bus_DV), .i_bhw(i_bhw),
        .i_write_notread(i_write_notread), .o_bus_data(o_bus_data), .o_bus_DV(o_bus_DV),
        .o_interrupt(o_interrupt), .i_ack(i_ack), .o_claim_id(o_claim_id)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wd;
        bit          exp_dv;
        logic [31:0] exp_rd;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    int   m_prio [NUM_SRC];
    bit   m_en   [NUM_SRC];
    bit   m_pend [NUM_SRC];
    bit   m_infl [NUM_SRC];
`ifdef PLIC_EDGE_TRIGGER_EN
    bit   m_irq_prev [NUM_SRC];
`endif
    int   m_thr;
    bit   m_hold;
    bit   e_int, e_dv;
    int   e_claim;
    logic [31:0] e_data;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Highest priority among eligible sources, then the lowest id holding it.
    function automatic int model_winner();
        int best = 0;
        for (int i = 1; i < int'(NUM_SRC); i++)
            if (m_pend[i] && m_en[i] && m_prio[i] > m_thr && m_prio[i] > best) best = m_prio[i];
        if (best == 0) return 0;
        for (int i = 1; i < int'(NUM_SRC); i++)
            if (m_pend[i] && m_en[i] && m_prio[i] == best) return i;
        return 0;
    endfunction

    function automatic logic [31:0] pack_bits(input int which);
        logic [31:0] r = '0;
        for (int i = 0; i < int'(NUM_SRC); i++)
            if ((which == 0 && m_pend[i]) || (which == 1 && m_en[i])) r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        logic [31:0] off = addr - BASE;
        int id;
        if (addr < BASE || off > 32'h003F_FFFF) return '0;
        if (off < 32'h1000 && off % 4 == 0) begin
            id = int'(off / 4);
            return (id >= 1 && id < int'(NUM_SRC)) ? 32'(m_prio[id]) : 32'h0;
        end
        case (off)
            32'h0000_1000: return pack_bits(0);
            32'h0000_2000: return pack_bits(1);
            32'h0020_0000: return 32'(m_thr);
            32'h0020_0004: return 32'(model_winner());
            default:       return '0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            m_prio[i] = 0; m_en[i] = 0; m_pend[i] = 0; m_infl[i] = 0;
`ifdef PLIC_EDGE_TRIGGER_EN
            m_irq_prev[i] = 0;
`endif
        end
        m_thr = 0; m_hold = 0;
    endtask

    // One clock: advance the model on the current inputs, clock the DUT, compare outputs.
    task automatic tick();
        int          w      = model_winner();
        logic [31:0] off    = i_bus_address - BASE;
        bit          in_rng = (i_bus_address >= BASE) && (off <= 32'h003F_FFFF);
        bit          acc    = i_bus_DV && in_rng;
        bit          rd     = acc && !i_write_notread;
        bit          wr     = acc && i_write_notread;
        logic [31:0] rv     = model_read(i_bus_address);
        bit          req;
        int          id;
        if (!i_rst_n) begin
            model_reset();
            e_int = 0; e_dv = 0; e_claim = 0; e_data = '0;
        end else begin
            e_int = (w != 0) && !m_hold; e_claim = w; e_dv = acc; e_data = rd ? rv : '0;
            for (int i = 1; i < int'(NUM_SRC); i++) begin
`ifdef PLIC_EDGE_TRIGGER_EN
                req = i_irq[i] && !m_irq_prev[i];
                m_irq_prev[i] = i_irq[i];
`else
                req = i_irq[i];
`endif
                if (req && !m_infl[i]) m_pend[i] = 1;
            end
            if (wr) begin
                if (off < 32'h1000 && off % 4 == 0) begin
                    id = int'(off / 4);
                    if (id >= 1 && id < int'(NUM_SRC)) m_prio[id] = int'(i_bus_data[PRIO_W-1:0]);
                end else if (off == 32'h0000_2000) begin
                    for (int i = 1; i < int'(NUM_SRC); i++) m_en[i] = i_bus_data[i];
                end else if (off == 32'h0020_0000) begin
                    m_thr = int'(i_bus_data[PRIO_W-1:0]);
                end else if (off == 32'h0020_0004 && i_bus_data < NUM_SRC) begin
                    if (m_infl[int'(i_bus_data)]) m_infl[int'(i_bus_data)] = 0;
                end
            end
            if (rd && off == 32'h0020_0004 && w != 0) begin
                m_pend[w] = 0; m_infl[w] = 1; m_hold = 0;
            end else if (i_ack) begin
                m_hold = 1;
            end
        end
        @(posedge i_clk);
        #1;
        check("model.interrupt", 32'(o_interrupt), 32'(e_int));
        check("model.claim_id", 32'(o_claim_id), 32'(e_claim));
        check("model.bus_dv", 32'(o_bus_DV), 32'(e_dv));
        check("model.bus_data", o_bus_data, e_data);
    endtask

    task automatic bus(input bit we, input logic [31:0] addr, input logic [31:0] wd);
        i_bus_DV = 1'b1; i_write_notread = we; i_bus_address = addr; i_bus_data = wd; i_bhw = 3'd2;
        tick();
        i_bus_DV = 1'b0; i_write_notread = 1'b0; i_bus_data = '0;
    endtask

    task automatic rd_expect(input string nm, input logic [31:0] addr, input logic [31:0] exp);
        bus(1'b0, addr, '0);
        check({nm, ".dv"}, 32'(o_bus_DV), 32'd1);
        check(nm, o_bus_data, exp);
    endtask

    task automatic prio_wr(input int id, input int p);
        bus(1'b1, BASE + 32'(id * 4), 32'(p));
    endtask

    task automatic pulse(input logic [NUM_SRC-1:0] m);
        i_irq = m;
        tick();
        i_irq = '0;
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0; i_irq = '0; i_ack = 1'b0;
        tick();
        i_rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t vecs [21];
        int   op;
        i_rst_n = 1'b0; i_irq = '0; i_bus_data = '0; i_bus_address = '0;
        i_bus_DV = 1'b0; i_bhw = '0; i_write_notread = 1'b0; i_ack = 1'b0;
        tick(); tick();
        check("rst.interrupt", 32'(o_interrupt), 32'd0);
        check("rst.claim_id", 32'(o_claim_id), 32'd0);
        check("rst.bus_dv", 32'(o_bus_DV), 32'd0);
        check("rst.bus_data", o_bus_data, 32'd0);
        i_rst_n = 1'b1;

        // Register map table: {we, addr, wdata, expected dv, expected read data}
        vecs[0]  = '{1'b0, A_PEND,               32'h0,         1'b1, 32'h0};
        vecs[1]  = '{1'b0, A_EN,                 32'h0,         1'b1, 32'h0};
        vecs[2]  = '{1'b0, A_THR,                32'h0,         1'b1, 32'h0};
        vecs[3]  = '{1'b0, A_CLM,                32'h0,         1'b1, 32'h0};
        vecs[4]  = '{1'b1, BASE + 32'h0C,        32'h7,         1'b1, 32'h0};
        vecs[5]  = '{1'b0, BASE + 32'h0C,        32'h0,         1'b1, 32'h7};
        vecs[6]  = '{1'b1, BASE + 32'h00,        32'h5,         1'b1, 32'h0};
        vecs[7]  = '{1'b0, BASE + 32'h00,        32'h0,         1'b1, 32'h0};
        vecs[8]  = '{1'b1, BASE + 32'h24,        32'h3,         1'b1, 32'h0};
        vecs[9]  = '{1'b0, BASE + 32'h24,        32'h0,         1'b1, 32'h0};
        vecs[10] = '{1'b1, A_EN,                 32'hFFFF_FFFF, 1'b1, 32'h0};
        vecs[11] = '{1'b0, A_EN,                 32'h0,         1'b1, 32'hFE};
        vecs[12] = '{1'b1, A_THR,                32'hF,         1'b1, 32'h0};
        vecs[13] = '{1'b0, A_THR,                32'h0,         1'b1, 32'h7};
        vecs[14] = '{1'b1, BASE + 32'h04,        32'hA,         1'b1, 32'h0};
        vecs[15] = '{1'b0, BASE + 32'h04,        32'h0,         1'b1, 32'h2};
        vecs[16] = '{1'b1, BASE + 32'h3000,      32'h55,        1'b1, 32'h0};
        vecs[17] = '{1'b0, BASE + 32'h3000,      32'h0,         1'b1, 32'h0};
        vecs[18] = '{1'b0, BASE + 32'h40_0000,   32'h0,         1'b0, 32'h0};
        vecs[19] = '{1'b1, BASE - 32'h4,         32'h1,         1'b0, 32'h0};
        vecs[20] = '{1'b0, A_CLM,                32'h0,         1'b1, 32'h0};
        for (int k = 0; k < 21; k++) begin
            bus(vecs[k].we, vecs[k].addr, vecs[k].wd);
            check($sformatf("vec%0d.dv", k), 32'(o_bus_DV), 32'(vecs[k].exp_dv));
            check($sformatf("vec%0d.data", k), o_bus_data, vecs[k].exp_rd);
            check($sformatf("vec%0d.interrupt", k), 32'(o_interrupt), 32'd0);
        end
        tick();
        check("idle.bus_dv", 32'(o_bus_DV), 32'd0);

        // Single source: latency, claim, ignored completes, real complete
        do_reset();
        prio_wr(3, 2); bus(1'b1, A_EN, 32'h08); bus(1'b1, A_THR, 32'h1);
        pulse(8'h08);
        check("t1.int_edge_n", 32'(o_interrupt), 32'd0);
        tick();
        check("t1.int_edge_n1", 32'(o_interrupt), 32'd1);
        rd_expect("t1.claim", A_CLM, 32'd3);
        rd_expect("t1.pend_clear", A_PEND, 32'h0);
        bus(1'b1, A_CLM, 32'd9); bus(1'b1, A_CLM, 32'd4);
        pulse(8'h08);
        rd_expect("t1.still_inflight", A_PEND, 32'h0);
        bus(1'b1, A_CLM, 32'd3);
        pulse(8'h08);
        rd_expect("t1.repend", A_PEND, 32'h08);

        // Priority order with a tie resolved to the lower id
        do_reset();
        prio_wr(2, 5); prio_wr(5, 5); prio_wr(6, 4); bus(1'b1, A_EN, 32'h64);
        pulse(8'h64);
        tick();
        check("t2.interrupt", 32'(o_interrupt), 32'd1);
        check("t2.claim_id", 32'(o_claim_id), 32'd2);
        rd_expect("t2.claim_a", A_CLM, 32'd2);
        rd_expect("t2.claim_b", A_CLM, 32'd5);
        rd_expect("t2.claim_c", A_CLM, 32'd6);
        rd_expect("t2.claim_none", A_CLM, 32'd0);

        // Threshold masking and unmasking
        do_reset();
        prio_wr(4, 5); bus(1'b1, A_EN, 32'h10); bus(1'b1, A_THR, 32'd5);
        pulse(8'h10); tick(); tick();
        check("t3.masked", 32'(o_interrupt), 32'd0);
        bus(1'b1, A_THR, 32'd4);
        check("t3.write_edge", 32'(o_interrupt), 32'd0);
        tick();
        check("t3.unmasked", 32'(o_interrupt), 32'd1);

        // Ack holds the line until the claim
        do_reset();
        prio_wr(1, 1); bus(1'b1, A_EN, 32'h02);
        pulse(8'h02); tick();
        check("t4.raised", 32'(o_interrupt), 32'd1);
        i_ack = 1'b1; tick(); i_ack = 1'b0; tick();
        check("t4.held", 32'(o_interrupt), 32'd0);
        rd_expect("t4.claim", A_CLM, 32'd1);
        bus(1'b1, A_CLM, 32'd1);
        pulse(8'h02); tick();
        check("t4.released", 32'(o_interrupt), 32'd1);

        // Held request after complete: level re-pends, edge does not
        do_reset();
        prio_wr(1, 1); bus(1'b1, A_EN, 32'h02);
        i_irq = 8'h02; tick(); tick();
        rd_expect("t5.claim", A_CLM, 32'd1);
        bus(1'b1, A_CLM, 32'd1);
        rd_expect("t5.pend_at_complete", A_PEND, 32'h0);
`ifdef PLIC_EDGE_TRIGGER_EN
        rd_expect("t5.pend_after", A_PEND, 32'h0);
`else
        rd_expect("t5.pend_after", A_PEND, 32'h02);
`endif
        i_irq = '0;

        // Ack and claim in the same cycle: claim wins
        do_reset();
        prio_wr(1, 3); prio_wr(2, 2); bus(1'b1, A_EN, 32'h06);
        pulse(8'h06); tick();
        check("t6.raised", 32'(o_interrupt), 32'd1);
        i_ack = 1'b1;
        rd_expect("t6.claim", A_CLM, 32'd1);
        i_ack = 1'b0;
        tick();
        check("t6.no_hold", 32'(o_interrupt), 32'd1);

        // Reset on the request edge suppresses the completion strobe
        i_rst_n = 1'b0; i_bus_DV = 1'b1; i_write_notread = 1'b0; i_bus_address = A_EN;
        tick();
        i_bus_DV = 1'b0; i_rst_n = 1'b1;
        check("t7.dv_suppressed", 32'(o_bus_DV), 32'd0);

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(3) == 0) i_irq = NUM_SRC'($urandom);
            i_ack   = ($urandom_range(15) == 0);
            i_rst_n = ($urandom_range(799) != 0);
            if ($urandom_range(1) == 1) begin
                op = int'($urandom_range(7));
                i_bus_DV = 1'b1; i_bhw = 3'($urandom); i_bus_data = $urandom;
                case (op)
                    0: begin i_write_notread = 1'b1; i_bus_address = BASE + 32'($urandom_range(9) * 4); end
                    1: begin i_write_notread = 1'b0; i_bus_address = BASE + 32'($urandom_range(9) * 4); end
                    2: begin i_write_notread = 1'b1; i_bus_address = A_EN; end
                    3: begin i_write_notread = 1'b1; i_bus_address = A_THR; i_bus_data = 32'($urandom_range(3)); end
                    4, 5: begin i_write_notread = 1'b0; i_bus_address = A_CLM; end
                    6: begin i_write_notread = 1'b1; i_bus_address = A_CLM; i_bus_data = 32'($urandom_range(9)); end
                    default: begin
                        i_write_notread = 1'($urandom_range(1));
                        case ($urandom_range(7))
                            0: i_bus_address = A_PEND;
                            1: i_bus_address = A_EN;
                            2: i_bus_address = A_THR;
                            3: i_bus_address = BASE + 32'h3000;
                            4: i_bus_address = BASE + 32'h40_0000;
                            5: i_bus_address = BASE - 32'h4;
                            6: i_bus_address = BASE + 32'h20_0008;
                            default: i_bus_address = BASE + 32'h0FFC;
                        endcase
                    end
                endcase
            end else begin
                i_bus_DV = 1'b0;
            end
            tick();
        end
        i_bus_DV = 1'b0; i_rst_n = 1'b1; i_ack = 1'b0; i_irq = '0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
